// File: rtl/weather_sensor_decoder.sv
// weather_sensor_decoder
// Serial weather-sensor frame decoder. A frame is 26 bits, MSB first:
//   8'hA5 header, thunderstorm(1), wind(6), visibility(2), temperature(8), parity(1).
// The frame is good when the 17 payload bits plus the parity bit hold an even
// number of ones. Good frames update the data outputs and pulse frame_valid.
// Bad frames pulse frame_error and leave the data outputs unchanged.
// Bits are consumed only on edges where svalid=1. svalid=0 holds the decoder
// where it is, with no timeout.
//
// Optional feature, macro WSD_STALE_DETECT_EN:
//   defined   - a 16-bit saturating counter measures the cycles since the last
//               good frame, and sensor_stale is raised once it reaches STALE_CYCLES.
//   undefined - no counter exists and sensor_stale is tied to 0.
//
// Handshake: the sensor side has no back-pressure. sdata is sampled on each
// rising edge where svalid=1. frame_valid and frame_error are one-cycle
// pulses that are mutually exclusive.
module weather_sensor_decoder #(
    parameter int unsigned STALE_CYCLES = 1000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       sdata,
    input  logic       svalid,
    output logic       thunderstorm,
    output logic [5:0] wind,
    output logic [1:0] visibility,
    output logic [7:0] temperature,
    output logic       frame_valid,
    output logic       frame_error,
    output logic       sensor_stale,
    output logic [1:0] dec_state
);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        PARITY  = 2'd2
    } state_t;

    localparam logic [7:0]  HEADER      = 8'hA5;
    localparam logic [4:0]  LAST_BIT    = 5'd16;
    localparam logic [15:0] STALE_LIMIT = 16'(STALE_CYCLES);

    state_t      state_q, state_d;
    logic [7:0]  hdr_q, hdr_d;
    logic [16:0] stage_q, stage_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        thunder_q, thunder_d;
    logic [5:0]  wind_q, wind_d;
    logic [1:0]  vis_q, vis_d;
    logic [7:0]  temp_q, temp_d;
    logic        fv_q, fv_d;
    logic        fe_q, fe_d;

    logic [7:0]  hdr_shift;
    logic        parity_ok;

    assign hdr_shift = {hdr_q[6:0], sdata};
    // Even parity over the staged payload together with the incoming parity bit.
    assign parity_ok = ~(^{stage_q, sdata});

    // State, shift registers, data outputs and pulse flags.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= HUNT;
            hdr_q     <= 8'h00;
            stage_q   <= 17'd0;
            cnt_q     <= 5'd0;
            thunder_q <= 1'b0;
            wind_q    <= 6'd0;
            vis_q     <= 2'd0;
            temp_q    <= 8'd0;
            fv_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            stage_q   <= stage_d;
            cnt_q     <= cnt_d;
            thunder_q <= thunder_d;
            wind_q    <= wind_d;
            vis_q     <= vis_d;
            temp_q    <= temp_d;
            fv_q      <= fv_d;
            fe_q      <= fe_d;
        end
    end

    // Next-state logic. Nothing advances unless svalid qualifies the current bit.
    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        stage_d   = stage_q;
        cnt_d     = cnt_q;
        thunder_d = thunder_q;
        wind_d    = wind_q;
        vis_d     = vis_q;
        temp_d    = temp_q;
        fv_d      = 1'b0;
        fe_d      = 1'b0;
        if (svalid) begin
            case (state_q)
                HUNT: begin
                    hdr_d = hdr_shift;
                    if (hdr_shift == HEADER) begin
                        state_d = PAYLOAD;
                        cnt_d   = 5'd0;
                    end
                end
                PAYLOAD: begin
                    stage_d = {stage_q[15:0], sdata};
                    if (cnt_q == LAST_BIT) begin
                        state_d = PARITY;
                        cnt_d   = 5'd0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                PARITY: begin
                    // Clear the header register so frame bits never seed the next match.
                    state_d = HUNT;
                    hdr_d   = 8'h00;
                    if (parity_ok) begin
                        thunder_d = stage_q[16];
                        wind_d    = stage_q[15:10];
                        vis_d     = stage_q[9:8];
                        temp_d    = stage_q[7:0];
                        fv_d      = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    hdr_d   = 8'h00;
                end
            endcase
        end
    end

`ifdef WSD_STALE_DETECT_EN
    logic [15:0] stale_cnt_q, stale_cnt_d;

    // Cycles since the last good frame. The counter saturates at all-ones.
    always_comb begin
        stale_cnt_d = stale_cnt_q;
        if (fv_d) begin
            stale_cnt_d = 16'd0;
        end else if (stale_cnt_q != 16'hFFFF) begin
            stale_cnt_d = stale_cnt_q + 16'd1;
        end
    end

    // Stale counter register. It is not stalled by svalid.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stale_cnt_q <= 16'd0;
        end else begin
            stale_cnt_q <= stale_cnt_d;
        end
    end

    assign sensor_stale = (stale_cnt_q >= STALE_LIMIT);
`else
    // The feature is disabled, so this output is a constant 0. The limit
    // stays referenced so that both builds share the same parameter set.
    assign sensor_stale = 1'b0 & (STALE_LIMIT == 16'd0);
`endif

    assign thunderstorm = thunder_q;
    assign wind         = wind_q;
    assign visibility   = vis_q;
    assign temperature  = temp_q;
    assign frame_valid  = fv_q;
    assign frame_error  = fe_q;
    assign dec_state    = state_q;

endmodule
